mem_i2c_arb: RTL and testbench
==============================

# mem_i2c_arb

Two-master Wishbone B3 arbiter that shares the single 8-bit `ram_wb_b3` memory between the I2C-slave bridge (master 0) and a system/CPU Wishbone master (master 1). It grants the memory round-robin per Wishbone cycle and routes ack/data back to the owner only. A watchdog aborts any cycle the memory fails to acknowledge, so a hung transfer cannot lock out the other master.

## Interface
Parameters:
- `AW`, 10: Wishbone address width (byte address).
- `DW`, 8: Wishbone data width.
- `TIMEOUT`, 255: cycles of `stb` without `ack` before abort; legal range 1..255.

Ports:
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `m0_adr_i`, `m1_adr_i` in AW: master address.
- `m0_dat_i`, `m1_dat_i` in DW: master write data.
- `m0_sel_i`, `m1_sel_i` in 4: byte selects.
- `m0_we_i`, `m1_we_i` in 1: write enable.
- `m0_cyc_i`, `m1_cyc_i` in 1: cycle valid.
- `m0_stb_i`, `m1_stb_i` in 1: strobe.
- `m0_cti_i`, `m1_cti_i` in 3: cycle type.
- `m0_dat_o`, `m1_dat_o` out DW: read data, copy of `s_dat_i`.
- `m0_ack_o`, `m1_ack_o` out 1: acknowledge, owner only.
- `m0_err_o`, `m1_err_o` out 1: error (slave err or watchdog abort), owner only.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out 4, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1, `s_cti_o` out 3: memory-side master signals.
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1: memory-side responses. `rty` is ignored.
- `gnt_o` out 2: one-hot current owner, registered.
- `abort_cnt_o` out 8: saturating count of watchdog aborts.

## Operation
- States: IDLE, OWN0, OWN1, ABORT. Request `reqX = mX_cyc_i & mX_stb_i`.
- IDLE:
  - Only one request → OWN of that master.
  - Both request → the master that is not `last` (last owner) wins.
  - `last` resets to 1, so master 0 wins the first tie.
- OWNx:
  - Slave outputs are a mux of master x. `s_cyc_o = mx_cyc_i`, `s_stb_o = mx_stb_i`.
  - `mx_ack_o = s_ack_i` and `mx_err_o = s_err_i`, combinational. Non-owner ack/err are 0.
  - Grant is held for the whole cycle: `cyc` high, including bursts (any `cti`) and idle-`stb` gaps.
- Release, when owner `cyc` is sampled low:
  - `last <= x`.
  - If the other master requests → OWN of the other master directly, with no IDLE cycle.
  - Otherwise → IDLE.
- Watchdog:
  - 8-bit counter clears on grant, on `s_ack_i`, on `s_err_i`, and when `stb` is low.
  - Increments each owned cycle with `stb` high and no ack/err.
  - When the counter equals TIMEOUT-1 with no ack in that cycle:
    - `mx_err_o` = 1 for that cycle.
    - Next state ABORT.
    - `abort_cnt_o` increments, saturating at 255.
- ABORT:
  - `s_cyc_o`/`s_stb_o` = 0; all acks/errs = 0.
  - Stays until owner `cyc` is low, then applies the release rule above.
- In IDLE and ABORT, slave address/data/sel/we/cti drive 0.

## Timing
- Reset values:
  - `gnt_o` = 00, state IDLE, `last` = 1, watchdog = 0, `abort_cnt_o` = 0.
  - All `s_*` outputs 0; all `m*_ack_o`/`m*_err_o` 0.
- Grant latency: request sampled at edge N → `gnt_o` and `s_cyc_o` valid after edge N (cycle N+1). Minimum one wait cycle added per new grant.
- Throughput: once owned, zero added latency; single-cycle ack slave gives one transfer per clock.
- Handoff: owner drops `cyc` in cycle K while other requests → other owns from cycle K+1.
- Simultaneous `s_ack_i` and watchdog expiry: the ack wins, no abort.
- Master drops `cyc` mid-wait: release on that edge; a late `s_ack_i` after release is not routed to anyone.
- Reset asserted mid-cycle: all outputs return to reset values immediately (asynchronous).

## Test plan
- Reset:
  - Hold `rst_n_i` = 0, toggle all inputs → every output 0, `gnt_o` = 00.
  - Release → master 0 request granted, `gnt_o` = 01, one cycle later.
- Single master 0 write, `adr` 0x014, `dat` 0xA5, memory acks in 1 cycle → `m0_ack_o` pulse. Readback by master 1 returns `m1_dat_o` = 0xA5 with `m1_ack_o`; `m0_ack_o` stays 0.
- Tie from IDLE, repeated 4 times with both masters doing single reads → grants alternate 01,10,01,10. Masters see no ack during each other's tenure.
- Burst hold: master 1 does a 4-beat read (`cti` 010…111) while master 0 requests → master 0 waits until after beat 4, then owns in the next cycle with no IDLE cycle.
- Watchdog with TIMEOUT = 8 and a stubbed memory that never acks:
  - `m0_err_o` is high exactly at the 8th strobed cycle; `s_cyc_o` drops next cycle; `abort_cnt_o` = 1.
  - Master 1 is granted after master 0 drops `cyc`.
- Async reset asserted during an owned write wait state → `s_cyc_o` goes 0 without a clock edge; after release, the arbiter is in IDLE and `abort_cnt_o` = 0.

Source files
------------

// File: rtl/mem_i2c_arb.sv
// Round-robin two-master Wishbone B3 arbiter in front of the shared byte RAM.
// Each grant lasts one whole cyc; a watchdog aborts cycles the slave never terminates.
module mem_i2c_arb #(
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [2:0]    m1_cti_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic [2:0]    s_cti_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    gnt_o,
  output logic [7:0]    abort_cnt_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_wdog, w_wdog_nxt;
  logic [7:0] r_abort_cnt;
  logic [1:0] r_gnt, w_gnt_nxt;
  logic       w_req0, w_req1, w_own_cyc, w_own_stb, w_expire, w_rel;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_wdog      <= '0;
      r_abort_cnt <= '0;
      r_gnt       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_expire && r_abort_cnt != 8'hFF)
        r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_wdog_nxt  = r_wdog;
    w_expire    = 1'b0;
    w_rel       = 1'b0;
    case (r_state)
      IDLE: begin
        w_wdog_nxt = '0;
        if (w_req0 && (!w_req1 || r_last)) begin
          w_state_nxt = OWN0;
          w_owner_nxt = 1'b0;
        end else if (w_req1) begin
          w_state_nxt = OWN1;
          w_owner_nxt = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!w_own_cyc) begin
          w_rel = 1'b1;
        end else if (w_own_stb && !s_ack_i && !s_err_i) begin
          if (r_wdog == LP_WD_LAST) begin
            w_expire    = 1'b1;
            w_state_nxt = ABORT;
            w_wdog_nxt  = '0;
          end else begin
            w_wdog_nxt = r_wdog + 8'd1;
          end
        end else begin
          w_wdog_nxt = '0;
        end
      end
      default: w_rel = !w_own_cyc;
    endcase
    // Release from OWNx and ABORT share one path so handoff skips IDLE.
    if (w_rel) begin
      w_last_nxt = r_owner;
      w_wdog_nxt = '0;
      if (r_owner ? w_req0 : w_req1) begin
        w_owner_nxt = ~r_owner;
        w_state_nxt = r_owner ? OWN0 : OWN1;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    if (w_state_nxt == IDLE) w_gnt_nxt = 2'b00;
    else                     w_gnt_nxt = {w_owner_nxt, ~w_owner_nxt};
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_cti_o  = m0_cti_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_expire;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_cti_o  = m1_cti_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_expire;
      end
      default: ;
    endcase
  end

  assign gnt_o       = r_gnt;
  assign abort_cnt_o = r_abort_cnt;

endmodule

// File: tb/tb_mem_i2c_arb.sv
// Scoreboarded bench for mem_i2c_arb with a combinational-ack byte RAM and a
// behavioural model of memory contents and round-robin ownership.
module tb_mem_i2c_arb;

  typedef struct packed {
    logic       err;
    logic       chk;
    logic [7:0] dat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       mcyc [2];
  logic       mstb [2];
  logic       mwe  [2];
  logic [9:0] madr [2];
  logic [7:0] mdat [2];
  logic [3:0] msel [2];
  logic [2:0] mcti [2];

  logic [7:0] m0_dat_o, m1_dat_o;
  logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [9:0] s_adr_o;
  logic [7:0] s_dat_o, s_dat_i;
  logic [3:0] s_sel_o;
  logic       s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [2:0] s_cti_o;
  logic [1:0] gnt_o;
  logic [7:0] abort_cnt_o;

  mem_i2c_arb #(.AW(10), .DW(8), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_sel_i(msel[0]), .m0_we_i(mwe[0]),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_cti_i(mcti[0]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_sel_i(msel[1]), .m1_we_i(mwe[1]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_cti_i(mcti[1]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o), .abort_cnt_o(abort_cnt_o)
  );

  // Memory stub: ack in the same cycle as stb unless stalled or muted.
  logic [7:0] mem     [1024];
  logic       wr_done [1024];
  logic [7:0] model   [1024];
  logic       force_rand = 1'b1, mem_noack = 1'b0, rand_stall = 1'b0, r_stall = 1'b0;
  logic       rnd_ack = 1'b0, rnd_err = 1'b0;
  logic [7:0] rnd_dat = '0;
  int         stall_run = 0;

  function automatic logic [7:0] init_val(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'h2B};
  endfunction

  assign s_ack_i = force_rand ? rnd_ack : (s_cyc_o & s_stb_o & !mem_noack & !r_stall);
  assign s_err_i = force_rand ? rnd_err : 1'b0;
  assign s_dat_i = force_rand ? rnd_dat : (wr_done[s_adr_o] ? mem[s_adr_o] : init_val(s_adr_o));

  always @(posedge clk) begin
    if (!force_rand && s_ack_i && s_we_o) begin
      mem[s_adr_o]     <= s_dat_o;
      wr_done[s_adr_o] <= 1'b1;
    end
    if (rand_stall && stall_run < 3 && $urandom_range(0, 2) == 0) begin
      r_stall   <= 1'b1;
      stall_run <= stall_run + 1;
    end else begin
      r_stall   <= 1'b0;
      stall_run <= 0;
    end
  end

  int  n_chk = 0, n_fail = 0;
  sb_t q0[$], q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int m, input logic ack, input logic err, input logic [7:0] dat,
                        input logic own);
    sb_t e;
    check($sformatf("owner_only_m%0d", m), 32'(own), 32'd1);
    if ((m == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_resp_m%0d: got ack=%0b err=%0b expected no response", m, ack, err);
    end else begin
      e = (m == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("resp_err_m%0d", m), 32'(err), 32'(e.err));
      check($sformatf("resp_ack_m%0d", m), 32'(ack), 32'(!e.err));
      if (e.chk) check($sformatf("rd_data_m%0d", m), 32'(dat), 32'(e.dat));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !force_rand) begin
      if (m0_ack_o || m0_err_o) sb_pop(0, m0_ack_o, m0_err_o, m0_dat_o, gnt_o[0]);
      if (m1_ack_o || m1_err_o) sb_pop(1, m1_ack_o, m1_err_o, m1_dat_o, gnt_o[1]);
    end
  end

  logic [1:0] glog[$];
  logic [1:0] gnt_prev = '0;
  logic       log_en = 1'b0;
  always @(negedge clk) begin
    if (log_en && gnt_o != gnt_prev && gnt_o != 2'b00) glog.push_back(gnt_o);
    gnt_prev <= gnt_o;
  end

  task automatic m_drive(input int m, input logic cyc, input logic we, input logic [9:0] a,
                         input logic [7:0] d, input logic [2:0] cti);
    mcyc[m] = cyc; mstb[m] = cyc; mwe[m] = we; madr[m] = a;
    mdat[m] = d;   msel[m] = cyc ? 4'h1 : 4'h0; mcti[m] = cti;
  endtask

  // One Wishbone cycle of 'beats' transfers; waits = negedges until the last response.
  task automatic m_xfer(input int m, input logic we, input logic [9:0] a, input logic [7:0] d,
                        input int beats, output int waits);
    sb_t        e;
    logic [9:0] ab;
    int         t;
    waits = 0;
    @(posedge clk); #1;
    for (int b = 0; b < beats; b++) begin
      ab = 10'(a + 10'(b));
      m_drive(m, 1'b1, we, ab, 8'(d + 8'(b)),
              (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010));
      e.err = 1'b0;
      e.chk = !we;
      e.dat = model[ab];
      if (we) model[ab] = 8'(d + 8'(b));
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      t = 0;
      while (t < 100) begin
        @(negedge clk);
        waits++;
        t++;
        if ((m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o)) break;
      end
      if (t >= 100) check($sformatf("resp_timeout_m%0d", m), 32'(t), 32'd0);
      if (b < beats - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    m_drive(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int         w, w0, err_at, stb_cnt, mlast;
    logic [1:0] exp_g[$];
    for (int i = 0; i < 1024; i++) model[i] = init_val(10'(i));
    m_drive(0, 1'b0, 1'b0, '0, '0, '0);
    m_drive(1, 1'b0, 1'b0, '0, '0, '0);

    // Reset held with every input toggling: outputs must stay at zero.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++)
        m_drive(m, 1'($urandom), 1'($urandom), 10'($urandom), 8'($urandom), 3'($urandom));
      rnd_ack = 1'($urandom); rnd_err = 1'($urandom); rnd_dat = 8'($urandom);
      @(negedge clk);
      check("rst_outputs_zero", 32'(|{m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
            s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, gnt_o, abort_cnt_o}), 32'd0);
    end
    @(posedge clk); #1;
    m_drive(0, 1'b0, 1'b0, '0, '0, '0);
    m_drive(1, 1'b0, 1'b0, '0, '0, '0);
    force_rand = 1'b0;
    rst_n = 1'b1;

    fork
      m_xfer(0, 1'b0, 10'h100, 8'h00, 1, w);
      begin
        @(posedge clk); @(negedge clk);
        check("first_gnt_wait", 32'(gnt_o), 32'b00);
        @(negedge clk);
        check("first_gnt", 32'(gnt_o), 32'b01);
      end
    join
    check("first_latency", 32'(w), 32'd2);

    // Write by master 0, readback by master 1.
    m_xfer(0, 1'b1, 10'h014, 8'hA5, 1, w);
    check("wr_latency", 32'(w), 32'd2);
    m_xfer(1, 1'b0, 10'h014, 8'h00, 1, w);
    check("rd_latency", 32'(w), 32'd2);
    check("model_readback", 32'(model[10'h014]), 32'hA5);
    mlast = 1;

    // Repeated ties from IDLE; model: the master other than the last owner wins.
    glog.delete();
    log_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp_g.push_back(mlast ? 2'b01 : 2'b10);
      exp_g.push_back(mlast ? 2'b10 : 2'b01);
      fork
        m_xfer(0, 1'b0, 10'(10'h020 + 10'(r)), 8'h00, 1, w);
        m_xfer(1, 1'b0, 10'(10'h220 + 10'(r)), 8'h00, 1, w0);
      join
    end
    @(negedge clk);
    log_en = 1'b0;
    check("tie_seq_len", 32'(glog.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < glog.size(); i++)
      check($sformatf("tie_gnt_%0d", i), 32'(glog[i]), 32'(exp_g[i]));

    // Burst hold and direct handoff.
    fork
      begin
        m_xfer(1, 1'b0, 10'h300, 8'h00, 4, w);
        @(negedge clk);
        check("burst_hold_gnt", 32'(gnt_o), 32'b10);
        @(negedge clk);
        check("burst_handoff_gnt", 32'(gnt_o), 32'b01);
      end
      begin
        @(posedge clk);
        m_xfer(0, 1'b0, 10'h0A0, 8'h00, 1, w0);
      end
    join
    check("burst_latency", 32'(w), 32'd5);

    // Watchdog: memory never acks master 0.
    mem_noack = 1'b1;
    @(posedge clk); #1;
    m_drive(0, 1'b1, 1'b1, 10'h030, 8'h3C, 3'b000);
    q0.push_back('{err: 1'b1, chk: 1'b0, dat: 8'h00});
    @(negedge clk);
    @(posedge clk); #1;
    m_drive(1, 1'b1, 1'b0, 10'h240, 8'h00, 3'b000);
    q1.push_back('{err: 1'b0, chk: 1'b1, dat: model[10'h240]});
    stb_cnt = 0;
    err_at = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_stb_o) stb_cnt++;
      if (m0_err_o) begin
        err_at = stb_cnt;
        break;
      end
    end
    check("wdog_err_at_stb", 32'(err_at), 32'd8);
    @(negedge clk);
    check("wdog_cyc_dropped", 32'({s_cyc_o, s_stb_o}), 32'd0);
    check("wdog_err_one_cycle", 32'(m0_err_o), 32'd0);
    check("wdog_abort_cnt", 32'(abort_cnt_o), 32'd1);
    mem_noack = 1'b0;
    @(posedge clk); #1;
    m_drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("wdog_m1_gnt", 32'(gnt_o), 32'b10);
    check("wdog_m1_ack", 32'(m1_ack_o), 32'd1);
    @(posedge clk); #1;
    m_drive(1, 1'b0, 1'b0, '0, '0, '0);

    // Random contention on disjoint address halves with a stalling memory.
    rand_stall = 1'b1;
    fork
      begin
        int wa;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          m_xfer(0, 1'($urandom), 10'($urandom_range(0, 508)), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4 : 1, wa);
        end
      end
      begin
        int wb;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          m_xfer(1, 1'($urandom), 10'($urandom_range(512, 1020)), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4 : 1, wb);
        end
      end
    join
    rand_stall = 1'b0;
    repeat (4) @(posedge clk);
    check("sb_empty_m0", 32'(q0.size()), 32'd0);
    check("sb_empty_m1", 32'(q1.size()), 32'd0);
    check("no_extra_aborts", 32'(abort_cnt_o), 32'd1);

    // Asynchronous reset during an owned wait state.
    mem_noack = 1'b1;
    @(posedge clk); #1;
    m_drive(0, 1'b1, 1'b1, 10'h040, 8'h77, 3'b000);
    repeat (3) @(negedge clk);
    check("ar_owned_cyc", 32'(s_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cyc_async", 32'({s_cyc_o, s_stb_o}), 32'd0);
    check("ar_gnt_async", 32'(gnt_o), 32'b00);
    check("ar_abort_cnt", 32'(abort_cnt_o), 32'd0);
    @(posedge clk); #1;
    m_drive(0, 1'b0, 1'b0, '0, '0, '0);
    mem_noack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_idle_gnt", 32'(gnt_o), 32'b00);
    check("ar_idle_abort", 32'(abort_cnt_o), 32'd0);
    m_xfer(1, 1'b0, 10'h260, 8'h00, 1, w);
    check("ar_regrant_latency", 32'(w), 32'd2);
    repeat (2) @(posedge clk);
    check("final_sb_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
